draw_triangle: RTL and testbench
================================

Name: draw_triangle

Overview:
- Wireframe triangle rasteriser for the 640x480 frame-buffer pipeline.
- Takes three screen-space vertices and emits the pixel coordinates of edges V1->V2, V2->V3, V3->V1 in sequence, one pixel per clock, using an internal Bresenham line engine.
- Sits between the vertex/projection stage and the frame-buffer writer.

Parameters:
- COORD_W, 10, bit width of each x/y coordinate.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- draw_triangle_start  in  1  level request to draw; sampled in IDLE only.
- V1  in  [1:0][COORD_W-1:0]  vertex 1; index 0 = x, index 1 = y.
- V2  in  [1:0][COORD_W-1:0]  vertex 2; same layout.
- V3  in  [1:0][COORD_W-1:0]  vertex 3; same layout.
- DrawX  out  COORD_W  x of the current plotted pixel (registered).
- DrawY  out  COORD_W  y of the current plotted pixel (registered).
- draw_triangle_done  out  1  high while in DONE state.

Behaviour:
- Reset (synchronous, active-high):
  - FSM -> IDLE, line engine -> idle.
  - DrawX = 0, DrawY = 0, draw_triangle_done = 0.
  - Reset asserted mid-draw aborts immediately, with the same values.
- FSM states: IDLE, L1_LOAD, L1_WAIT, L2_LOAD, L2_WAIT, L3_LOAD, L3_WAIT, DONE.
- IDLE: when draw_triangle_start = 1, go to L1_LOAD. Vertices are captured into internal registers at this edge; later input changes are ignored until the next IDLE.
- Ln_LOAD (one cycle):
  - Drive line endpoints (x0,y0,x1,y1); pulse draw_line_start = 1; go to Ln_WAIT.
  - Line 1 = V1->V2, line 2 = V2->V3, line 3 = V3->V1.
- Ln_WAIT: hold until draw_line_done, then go to L(n+1)_LOAD; after line 3, go to DONE.
- DONE:
  - draw_triangle_done = 1.
  - Stay while draw_triangle_start = 1; return to IDLE when it is 0.
  - done is a level, not a pulse.
- draw_triangle_start while busy (not IDLE) is ignored.
- Line engine (Bresenham, all octants, endpoints inclusive):
  - On start it latches endpoints and computes:
    - dx = |x1-x0|, dy = -|y1-y0|
    - sx/sy = +1/-1 from the endpoint ordering
    - err = dx+dy, signed COORD_W+2 bits
  - Emits one pixel per clock starting at (x0,y0).
  - e2 = 2*err. If e2 >= dy: err += dy, x += sx. If e2 <= dx: err += dx, y += sy.
  - After emitting (x1,y1), pulse draw_line_done for exactly one cycle.
  - Pixel count per line = max(|dx|,|dy|)+1.
- DrawX/DrawY update only on emitted pixels and hold their last value otherwise.
- Timing:
  - First pixel appears at most 3 cycles after start is sampled.
  - Pixels within a line are consecutive cycles.
  - Gap between lines is at most 3 cycles.
  - done is asserted at most 3 cycles after the last pixel.
- Shared vertices are emitted twice, once per adjacent edge. This is allowed.
- Degenerate cases:
  - Coincident vertices: a single-pixel line.
  - All three equal: 3 pixels, all the same coordinate.
- No clipping; coordinates pass through unmodified. Unsigned 10-bit arithmetic; no wrap occurs since endpoints bound all steps.

Optional Feature:
- Macro DRAW_TRIANGLE_PIXEL_VALID_EN.
- Defined: adds output port pixel_valid (1 bit), high exactly in cycles where DrawX/DrawY hold a newly emitted pixel; reset value 0.
- Undefined: port absent; the consumer infers validity from FSM timing; all other behaviour identical.

Decomposition:
- Package draw_pkg contains:
  - COORD_W = 10, X_IDX = 0, Y_IDX = 1, SCREEN_W = 640, SCREEN_H = 480.
  - typedef coord_t (logic [COORD_W-1:0]).
  - typedef vertex_t (logic [1:0][COORD_W-1:0]).
  - enum tri_state_t for the FSM.
- Sub-module draw_line: the Bresenham engine.
  - Ports: Clk, Reset, draw_line_start, x0, y0, x1, y1, DrawX, DrawY, draw_line_done.
  - draw_triangle instantiates it once; the internal signals x0, y0, x1, y1, draw_line_start, draw_line_done and curr_state are hierarchically visible for debug.

Test Plan:
- Reset, then V1=(20,20), V2=(40,20), V3=(20,40), start=1:
  - 21 pixels (20..40,20), then 21 diagonal pixels (40,20)->(20,40), then 21 pixels (20,40..20).
  - done high; 63 pixels total.
- V1=V2=V3=(5,7): three single pixels (5,7); done within 12 cycles of start.
- Steep reversed triangle V1=(100,10), V2=(90,60), V3=(120,30):
  - Each edge is a contiguous 8-connected path with endpoints inclusive.
  - Pixel counts: 51, 31, 21.
- Reset asserted mid line 2: next cycle DrawX = DrawY = 0, done = 0, FSM IDLE; start again redraws from line 1.
- Change V1 to (0,0) during the draw, and pulse start while busy: output unaffected.
- Hold start in DONE: done stays 1. Drop start: IDLE and done = 0 next cycle; re-raise start: redraw. With the macro defined, pixel_valid count equals 63 for scenario 1.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the wireframe triangle rasteriser.
//   COORD_W          : coordinate width (10 bits covers 640x480)
//   X_IDX / Y_IDX    : index of x / y inside a vertex_t
//   SCREEN_W/H       : frame-buffer dimensions (no clipping is done here)
//   tri_state_t      : triangle sequencer states
package draw_pkg;
  localparam int COORD_W  = 10;
  localparam int X_IDX    = 0;
  localparam int Y_IDX    = 1;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic [1:0][COORD_W-1:0] vertex_t;

  typedef enum logic [2:0] {
    IDLE, L1_LOAD, L1_WAIT, L2_LOAD, L2_WAIT, L3_LOAD, L3_WAIT, DONE
  } tri_state_t;
endpackage

// File: rtl/draw_line.sv
// Bresenham line engine, all octants, endpoints inclusive.
//   Clk, Reset (sync, active high)
//   draw_line_start : latch x0,y0,x1,y1 (honoured only when idle)
//   DrawX/DrawY     : registered pixel, holds between pixels
//   draw_line_done  : one-cycle pulse, coincident with the last pixel
//   pixel_valid     : (DRAW_TRIANGLE_PIXEL_VALID_EN only) new pixel this cycle
// Optional macro: DRAW_TRIANGLE_PIXEL_VALID_EN
module draw_line
  import draw_pkg::*;
#(
  parameter int COORD_W = draw_pkg::COORD_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               draw_line_start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               draw_line_done
`ifdef DRAW_TRIANGLE_PIXEL_VALID_EN
  ,output logic              pixel_valid
`endif
);
  localparam int EW = COORD_W + 2;

  logic               busy;
  logic               pix_vld;
  logic               last_q;
  logic [COORD_W-1:0] x, y, xe, ye;
  logic               sx_neg, sy_neg;
  logic signed [EW-1:0] dx, dy, err, err_nxt;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic [COORD_W-1:0] dxa, dya;
  logic               step_x, step_y, last;

  always_comb begin
    dxa    = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dya    = (y1 >= y0) ? y1 - y0 : y0 - y1;
    // e2 needs one more bit than err; compare at that width
    e2     = $signed({err, 1'b0});
    dx_w   = $signed({dx[EW-1], dx});
    dy_w   = $signed({dy[EW-1], dy});
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
    err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    last   = (x == xe) && (y == ye);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy    <= 1'b0;
      pix_vld <= 1'b0;
      last_q  <= 1'b0;
      DrawX   <= '0;
      DrawY   <= '0;
    end else begin
      pix_vld <= 1'b0;
      last_q  <= 1'b0;
      if (busy) begin
        DrawX   <= x;
        DrawY   <= y;
        pix_vld <= 1'b1;
        last_q  <= last;
        if (last) begin
          busy <= 1'b0;
        end else begin
          err <= err_nxt;
          if (step_x) x <= sx_neg ? x - 1'b1 : x + 1'b1;
          if (step_y) y <= sy_neg ? y - 1'b1 : y + 1'b1;
        end
      end else if (draw_line_start) begin
        busy   <= 1'b1;
        x      <= x0;
        y      <= y0;
        xe     <= x1;
        ye     <= y1;
        sx_neg <= (x1 < x0);
        sy_neg <= (y1 < y0);
        dx     <= $signed({2'b00, dxa});
        dy     <= -$signed({2'b00, dya});
        err    <= $signed({2'b00, dxa}) - $signed({2'b00, dya});
      end
    end
  end

  // done shares the cycle with the final (x1,y1) pixel
  assign draw_line_done = pix_vld & last_q;

`ifdef DRAW_TRIANGLE_PIXEL_VALID_EN
  assign pixel_valid = pix_vld;
`endif
endmodule

// File: rtl/draw_triangle.sv
// Wireframe triangle rasteriser: V1->V2, V2->V3, V3->V1 via one draw_line.
//   Clk, Reset (sync, active high)
//   draw_triangle_start : level request, sampled in IDLE only
//   V1/V2/V3            : vertices, [X_IDX]=x, [Y_IDX]=y; captured at start
//   DrawX/DrawY         : current pixel (registered)
//   draw_triangle_done  : level, high while in DONE
//   pixel_valid         : (DRAW_TRIANGLE_PIXEL_VALID_EN only) new pixel flag
// Optional macro: DRAW_TRIANGLE_PIXEL_VALID_EN
module draw_triangle
  import draw_pkg::*;
#(
  parameter int COORD_W = draw_pkg::COORD_W
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    draw_triangle_start,
  input  logic [1:0][COORD_W-1:0] V1,
  input  logic [1:0][COORD_W-1:0] V2,
  input  logic [1:0][COORD_W-1:0] V3,
  output logic [COORD_W-1:0]      DrawX,
  output logic [COORD_W-1:0]      DrawY,
  output logic                    draw_triangle_done
`ifdef DRAW_TRIANGLE_PIXEL_VALID_EN
  ,output logic                   pixel_valid
`endif
);
  tri_state_t curr_state, next_state;
  logic [1:0][COORD_W-1:0] v1_q, v2_q, v3_q;
  logic [1:0][COORD_W-1:0] pa, pb;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic draw_line_start, draw_line_done;

  always_ff @(posedge Clk) begin
    if (Reset) curr_state <= IDLE;
    else       curr_state <= next_state;
  end

  // Vertices are frozen for the whole draw so upstream may move on
  always_ff @(posedge Clk) begin
    if (curr_state == IDLE && draw_triangle_start) begin
      v1_q <= V1;
      v2_q <= V2;
      v3_q <= V3;
    end
  end

  always_comb begin
    next_state      = curr_state;
    draw_line_start = 1'b0;
    pa              = v1_q;
    pb              = v2_q;
    case (curr_state)
      IDLE:    if (draw_triangle_start) next_state = L1_LOAD;
      L1_LOAD: begin draw_line_start = 1'b1; next_state = L1_WAIT; end
      L1_WAIT: if (draw_line_done) next_state = L2_LOAD;
      L2_LOAD: begin
        pa = v2_q; pb = v3_q;
        draw_line_start = 1'b1; next_state = L2_WAIT;
      end
      L2_WAIT: begin
        pa = v2_q; pb = v3_q;
        if (draw_line_done) next_state = L3_LOAD;
      end
      L3_LOAD: begin
        pa = v3_q; pb = v1_q;
        draw_line_start = 1'b1; next_state = L3_WAIT;
      end
      L3_WAIT: begin
        pa = v3_q; pb = v1_q;
        if (draw_line_done) next_state = DONE;
      end
      DONE:    if (!draw_triangle_start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    x0 = pa[X_IDX];
    y0 = pa[Y_IDX];
    x1 = pb[X_IDX];
    y1 = pb[Y_IDX];
  end

  assign draw_triangle_done = (curr_state == DONE);

  draw_line #(.COORD_W(COORD_W)) u_line (
    .Clk             (Clk),
    .Reset           (Reset),
    .draw_line_start (draw_line_start),
    .x0              (x0),
    .y0              (y0),
    .x1              (x1),
    .y1              (y1),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .draw_line_done  (draw_line_done)
`ifdef DRAW_TRIANGLE_PIXEL_VALID_EN
    ,.pixel_valid    (pixel_valid)
`endif
  );
endmodule

// File: tb/tb_draw_triangle.sv
module tb_draw_triangle;
  localparam int CW = 10;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              draw_triangle_start;
  logic [1:0][CW-1:0] V1, V2, V3;
  logic [CW-1:0]     DrawX, DrawY;
  logic              draw_triangle_done;
  logic              pv;

  always #5 Clk = ~Clk;

  draw_triangle #(.COORD_W(CW)) dut (
    .Clk                 (Clk),
    .Reset               (Reset),
    .draw_triangle_start (draw_triangle_start),
    .V1                  (V1),
    .V2                  (V2),
    .V3                  (V3),
    .DrawX               (DrawX),
    .DrawY               (DrawY),
    .draw_triangle_done  (draw_triangle_done)
`ifdef DRAW_TRIANGLE_PIXEL_VALID_EN
    ,.pixel_valid        (pv)
`endif
  );

`ifndef DRAW_TRIANGLE_PIXEL_VALID_EN
  assign pv = dut.u_line.pix_vld;
`endif

  typedef struct { int x; int y; } pix_t;
  typedef struct {
    int ax, ay, bx, by, cx, cy;
    int npix;
    int max_cyc;
    bit disturb;
  } vec_t;

  pix_t exp_q[$];
  vec_t tbl[3];
  int total = 0;
  int bad   = 0;
  int idle  = 0;
  int npix  = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference Bresenham walk, endpoints inclusive
  task automatic push_line(int x0, int y0, int x1, int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0;
    for (int n = 0; n < 4096; n++) begin
      pix_t p;
      p.x = x; p.y = y;
      exp_q.push_back(p);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // One cycle: sample at negedge, score any emitted pixel
  task automatic tick();
    @(negedge Clk);
    if (pv) begin
      if (idle > 0) chk("pixel_gap_le3", int'(idle <= 3), 1);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_pixel act=(%0d,%0d) exp=none", DrawX, DrawY);
      end else begin
        pix_t p;
        p = exp_q.pop_front();
        if (int'(DrawX) != p.x || int'(DrawY) != p.y) begin
          bad++;
          $display("FAIL pixel act=(%0d,%0d) exp=(%0d,%0d)", DrawX, DrawY, p.x, p.y);
        end
      end
      idle = 0;
      npix++;
    end else begin
      idle++;
    end
  endtask

  task automatic load(vec_t t);
    V1[0] = 10'(t.ax); V1[1] = 10'(t.ay);
    V2[0] = 10'(t.bx); V2[1] = 10'(t.by);
    V3[0] = 10'(t.cx); V3[1] = 10'(t.cy);
    exp_q.delete();
    push_line(t.ax, t.ay, t.bx, t.by);
    push_line(t.bx, t.by, t.cx, t.cy);
    push_line(t.cx, t.cy, t.ax, t.ay);
    npix = 0;
    idle = 0;
    draw_triangle_start = 1'b1;
  endtask

  task automatic run_draw(vec_t t);
    int cyc;
    load(t);
    cyc = 0;
    while (!draw_triangle_done && cyc < t.max_cyc) begin
      tick();
      cyc++;
      if (t.disturb && cyc == 4) begin
        V1 = '0;
        draw_triangle_start = 1'b0;
      end
      if (t.disturb && cyc == 5) draw_triangle_start = 1'b1;
    end
    chk("done_in_budget", int'(draw_triangle_done), 1);
    chk("done_latency_le3", int'(idle <= 3), 1);
    chk("pixel_count", npix, t.npix);
    chk("queue_drained", exp_q.size(), 0);
    tick();
    chk("done_hold1", int'(draw_triangle_done), 1);
    tick();
    chk("done_hold2", int'(draw_triangle_done), 1);
    draw_triangle_start = 1'b0;
    tick();
    chk("done_drop", int'(draw_triangle_done), 0);
    chk("idle_after_drop", int'(dut.curr_state == draw_pkg::IDLE), 1);
  endtask

  initial begin
    tbl[0] = '{ax:20,  ay:20, bx:40, by:20, cx:20,  cy:40, npix:63,  max_cyc:300, disturb:1'b1};
    tbl[1] = '{ax:5,   ay:7,  bx:5,  by:7,  cx:5,   cy:7,  npix:3,   max_cyc:12,  disturb:1'b0};
    tbl[2] = '{ax:100, ay:10, bx:90, by:60, cx:120, cy:30, npix:103, max_cyc:400, disturb:1'b0};

    Reset = 1'b1;
    draw_triangle_start = 1'b0;
    V1 = '0; V2 = '0; V3 = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    chk("rst_drawx", int'(DrawX), 0);
    chk("rst_drawy", int'(DrawY), 0);
    chk("rst_done", int'(draw_triangle_done), 0);
    chk("rst_valid", int'(pv), 0);

    for (int i = 0; i < 3; i++) run_draw(tbl[i]);

    // Abort in the middle of edge 2, then redraw from edge 1
    begin
      int cyc;
      load(tbl[0]);
      cyc = 0;
      while (npix < 30 && cyc < 200) begin
        tick();
        cyc++;
      end
      chk("reached_line2", npix, 30);
      Reset = 1'b1;
      draw_triangle_start = 1'b0;
      exp_q.delete();
      tick();
      chk("abort_drawx", int'(DrawX), 0);
      chk("abort_drawy", int'(DrawY), 0);
      chk("abort_done", int'(draw_triangle_done), 0);
      chk("abort_idle", int'(dut.curr_state == draw_pkg::IDLE), 1);
      Reset = 1'b0;
      tick();
      chk("abort_quiet", int'(pv), 0);
      run_draw(tbl[0]);
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
